// File: rtl/bomberman_pkg.sv
// Shared types for the bomb manager: coordinate and player-id widths, slot-state encoding, cell distance helper.
package bomberman_pkg;

    localparam int GRID_DEF = 10;
    localparam int COORD_W  = 4;
    localparam int PID_W    = 1;
    localparam int FUSE_W   = 4;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        SLOT_IDLE    = 2'd0,
        SLOT_ARMED   = 2'd1,
        SLOT_PENDING = 2'd2
    } slot_state_e;

    // |a-b| evaluated with a sign bit so 0-15 never wraps to a small value
    function automatic logic [4:0] cell_dist(input coord_t a, input coord_t b);
        logic signed [4:0] diff;
        diff = $signed({1'b0, a}) - $signed({1'b0, b});
        if (diff < 5'sd0) begin
            cell_dist = 5'(-diff);
        end else begin
            cell_dist = 5'(diff);
        end
    endfunction

endpackage

// File: rtl/bomb_slot.sv
// One bomb slot: holds the cell, owner and fuse of a single bomb and walks IDLE -> ARMED -> PENDING -> IDLE.
module bomb_slot
    import bomberman_pkg::*;
#(
    parameter int FUSE_TICKS = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  coord_t           load_x,
    input  coord_t           load_y,
    input  logic [PID_W-1:0] load_owner,
    input  logic             tick,
    input  logic             free,
    input  logic             chain_hit,
    output slot_state_e      state,
    output coord_t           x,
    output coord_t           y,
    output logic [PID_W-1:0] owner
);

    slot_state_e       state_r, state_nxt_s;
    logic [FUSE_W-1:0] fuse_r, fuse_nxt_s;
    coord_t            x_r, y_r;
    logic [PID_W-1:0]  owner_r;

    // Next-state and fuse countdown; a chain hit overrides the fuse entirely
    always_comb begin
        state_nxt_s = state_r;
        fuse_nxt_s  = fuse_r;
        case (state_r)
            SLOT_IDLE: begin
                if (load) begin
                    state_nxt_s = SLOT_ARMED;
                    fuse_nxt_s  = FUSE_W'(FUSE_TICKS);
                end else begin
                    state_nxt_s = SLOT_IDLE;
                end
            end
            SLOT_ARMED: begin
                if (chain_hit) begin
                    state_nxt_s = SLOT_PENDING;
                end else if (tick && (fuse_r == FUSE_W'(1))) begin
                    state_nxt_s = SLOT_PENDING;
                end else if (tick) begin
                    fuse_nxt_s = fuse_r - FUSE_W'(1);
                end else begin
                    state_nxt_s = SLOT_ARMED;
                end
            end
            SLOT_PENDING: begin
                if (free) begin
                    state_nxt_s = SLOT_IDLE;
                end else begin
                    state_nxt_s = SLOT_PENDING;
                end
            end
            default: begin
                state_nxt_s = SLOT_IDLE;
                fuse_nxt_s  = '0;
            end
        endcase
    end

    // State, fuse and captured bomb cell/owner
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= SLOT_IDLE;
            fuse_r  <= '0;
            x_r     <= '0;
            y_r     <= '0;
            owner_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            fuse_r  <= fuse_nxt_s;
            if (load && (state_r == SLOT_IDLE)) begin
                x_r     <= load_x;
                y_r     <= load_y;
                owner_r <= load_owner;
            end
        end
    end

    assign state = state_r;
    assign x     = x_r;
    assign y     = y_r;
    assign owner = owner_r;

endmodule

// File: rtl/bomb_manager.sv
// Bomb manager top: drop allocation for two players, per-slot fuses, and a valid/ready blast event stream.
// Optional build macro CHAIN_REACTION_EN: a handshaken blast detonates ARMED bombs in line within RADIUS.
module bomb_manager
    import bomberman_pkg::*;
#(
    parameter int GRID       = GRID_DEF,
    parameter int NUM_SLOTS  = 4,
    parameter int MAX_PER_PL = 2,
    parameter int FUSE_TICKS = 3,
    parameter int RADIUS     = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic [1:0]   place_req,
    input  logic [3:0]   place_x0,
    input  logic [3:0]   place_y0,
    input  logic [3:0]   place_x1,
    input  logic [3:0]   place_y1,
    output logic [1:0]   place_ack,
    output logic [1:0]   place_nak,
    output logic         blast_valid,
    input  logic         blast_ready,
    output logic [3:0]   blast_x,
    output logic [3:0]   blast_y,
    output logic         blast_owner,
    output logic [2:0]   blast_radius,
    output logic [2:0]   live_count
);

    localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    slot_state_e      slot_state_s [NUM_SLOTS];
    coord_t           slot_x_s     [NUM_SLOTS];
    coord_t           slot_y_s     [NUM_SLOTS];
    logic [PID_W-1:0] slot_owner_s [NUM_SLOTS];
    coord_t           load_x_s     [NUM_SLOTS];
    coord_t           load_y_s     [NUM_SLOTS];
    logic [PID_W-1:0] load_owner_s [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] busy_s, load_s, free_s, chain_hit_s;

    logic [SLOT_W-1:0] idle_a_s, idle_b_s, idx1_s, pend_idx_s, blast_sel_r;
    logic              idle_a_found_s, idle_b_found_s, pend_found_s;
    logic              hit0_s, hit1_s, ok0_s, ok1_s, same_cell_s, hs_s;
    logic [3:0]        cnt0_s, cnt1_s;

    logic [1:0] place_ack_r, place_nak_r;
    logic       blast_valid_r, blast_owner_r;
    coord_t     blast_x_r, blast_y_r;
    logic [2:0] live_count_r;

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        bomb_slot #(.FUSE_TICKS(FUSE_TICKS)) u_slot (
            .clk       (clk),
            .rst       (rst),
            .load      (load_s[g]),
            .load_x    (load_x_s[g]),
            .load_y    (load_y_s[g]),
            .load_owner(load_owner_s[g]),
            .tick      (tick),
            .free      (free_s[g]),
            .chain_hit (chain_hit_s[g]),
            .state     (slot_state_s[g]),
            .x         (slot_x_s[g]),
            .y         (slot_y_s[g]),
            .owner     (slot_owner_s[g])
        );
    end

    // Drop evaluation: player 1 is judged as if player 0's accepted bomb were already placed
    always_comb begin
        hit0_s = 1'b0;  hit1_s = 1'b0;
        cnt0_s = 4'd0;  cnt1_s = 4'd0;
        idle_a_s = '0;  idle_b_s = '0;
        idle_a_found_s = 1'b0;
        idle_b_found_s = 1'b0;
        busy_s = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            busy_s[i] = (slot_state_s[i] != SLOT_IDLE);
            if (busy_s[i]) begin
                hit0_s = hit0_s | ((slot_x_s[i] == place_x0) && (slot_y_s[i] == place_y0));
                hit1_s = hit1_s | ((slot_x_s[i] == place_x1) && (slot_y_s[i] == place_y1));
                cnt0_s = cnt0_s + ((slot_owner_s[i] == 1'b0) ? 4'd1 : 4'd0);
                cnt1_s = cnt1_s + ((slot_owner_s[i] == 1'b1) ? 4'd1 : 4'd0);
            end else if (!idle_a_found_s) begin
                idle_a_found_s = 1'b1;
                idle_a_s       = SLOT_W'(i);
            end else if (!idle_b_found_s) begin
                idle_b_found_s = 1'b1;
                idle_b_s       = SLOT_W'(i);
            end else begin
                idle_b_found_s = 1'b1;
            end
        end
        same_cell_s = (place_x0 == place_x1) && (place_y0 == place_y1);
        ok0_s = place_req[0] && (place_x0 < COORD_W'(GRID)) && (place_y0 < COORD_W'(GRID))
                && !hit0_s && (cnt0_s < 4'(MAX_PER_PL)) && idle_a_found_s;
        ok1_s = place_req[1] && (place_x1 < COORD_W'(GRID)) && (place_y1 < COORD_W'(GRID))
                && !hit1_s && !(ok0_s && same_cell_s) && (cnt1_s < 4'(MAX_PER_PL))
                && (ok0_s ? idle_b_found_s : idle_a_found_s);
        idx1_s = ok0_s ? idle_b_s : idle_a_s;
    end

    // Steer accepted drops onto their slots
    always_comb begin
        load_s = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            load_s[i]       = (ok0_s && (idle_a_s == SLOT_W'(i))) || (ok1_s && (idx1_s == SLOT_W'(i)));
            load_x_s[i]     = (ok0_s && (idle_a_s == SLOT_W'(i))) ? place_x0 : place_x1;
            load_y_s[i]     = (ok0_s && (idle_a_s == SLOT_W'(i))) ? place_y0 : place_y1;
            load_owner_s[i] = (ok0_s && (idle_a_s == SLOT_W'(i))) ? 1'b0 : 1'b1;
        end
    end

    // Lowest-index PENDING slot, plus release and chain strobes for the blast being handshaken
    always_comb begin
        pend_idx_s   = '0;
        pend_found_s = 1'b0;
        free_s       = '0;
        chain_hit_s  = '0;
        hs_s         = blast_valid_r && blast_ready;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            pend_found_s = pend_found_s | (slot_state_s[i] == SLOT_PENDING);
            pend_idx_s   = (slot_state_s[i] == SLOT_PENDING) ? SLOT_W'(i) : pend_idx_s;
        end
        for (int i = 0; i < NUM_SLOTS; i++) begin
            free_s[i] = hs_s && (blast_sel_r == SLOT_W'(i));
`ifdef CHAIN_REACTION_EN
            chain_hit_s[i] = hs_s && (slot_state_s[i] == SLOT_ARMED)
                && (((slot_y_s[i] == blast_y_r) && (cell_dist(slot_x_s[i], blast_x_r) <= 5'(RADIUS)))
                 || ((slot_x_s[i] == blast_x_r) && (cell_dist(slot_y_s[i], blast_y_r) <= 5'(RADIUS))));
`else
            chain_hit_s[i] = 1'b0;
`endif
        end
    end

    // Registered drop responses, live counter and the blast output holding register
    always_ff @(posedge clk) begin
        if (rst) begin
            place_ack_r   <= 2'b00;
            place_nak_r   <= 2'b00;
            live_count_r  <= 3'd0;
            blast_valid_r <= 1'b0;
            blast_x_r     <= '0;
            blast_y_r     <= '0;
            blast_owner_r <= 1'b0;
            blast_sel_r   <= '0;
        end else begin
            place_ack_r  <= {ok1_s, ok0_s};
            place_nak_r  <= place_req & ~{ok1_s, ok0_s};
            live_count_r <= live_count_r + 3'(ok0_s) + 3'(ok1_s) - 3'(hs_s);
            if (hs_s) begin
                blast_valid_r <= 1'b0;
            end else if (!blast_valid_r && pend_found_s) begin
                blast_valid_r <= 1'b1;
                blast_x_r     <= slot_x_s[pend_idx_s];
                blast_y_r     <= slot_y_s[pend_idx_s];
                blast_owner_r <= slot_owner_s[pend_idx_s];
                blast_sel_r   <= pend_idx_s;
            end
        end
    end

    assign place_ack    = place_ack_r;
    assign place_nak    = place_nak_r;
    assign blast_valid  = blast_valid_r;
    assign blast_x      = blast_x_r;
    assign blast_y      = blast_y_r;
    assign blast_owner  = blast_owner_r;
    assign blast_radius = 3'(RADIUS);
    assign live_count   = live_count_r;

endmodule
